mmio_fabric: RTL and testbench

- Parametrised successor of the fixed-slot IO decoder; routes CPU memory-mapped IO requests to NUM_DEV device channels.
- Adds a valid/ready request handshake, per-device wait states, byte-lane write enables, a timeout, and error responses for unmapped slots.
- Sits between the core's IO port (address bit 31 set) and the device controllers (VRAM, SD, PS2, future devices).

---
 rtl/mmio_pkg.sv | 13 +
 rtl/mmio_lane_fmt.sv | 18 +
 rtl/mmio_fabric.sv | 164 ++++++++++++++++
 tb/tb_mmio_fabric.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and lane constants for the MMIO fabric and device controllers
package mmio_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        write;
    logic        byte_op;
  } req_t;
endpackage

// File: rtl/mmio_lane_fmt.sv
// mmio_lane_fmt: byte-lane replication for writes and lane extraction for reads
module mmio_lane_fmt
  import mmio_pkg::*;
(
  input  logic        byte_op,
  input  logic        a0,
  input  logic [15:0] wdata,
  input  logic [15:0] rword,
  output logic [15:0] wdata_fmt,
  output logic [1:0]  be,
  output logic [15:0] rdata_fmt
);
  always_comb begin
    wdata_fmt = byte_op ? {2{wdata[7:0]}} : wdata;
    be        = !byte_op ? BE_WORD : a0 ? BE_HI : BE_LO;
    rdata_fmt = !byte_op ? rword : {8'h00, a0 ? rword[15:8] : rword[7:0]};
  end
endmodule

// File: rtl/mmio_fabric.sv
// mmio_fabric: routes MMIO requests to NUM_DEV device channels with wait states,
// timeout and error responses
module mmio_fabric
  import mmio_pkg::*;
#(
  parameter int NUM_DEV    = 4,
  parameter int SEL_LSB    = 20,
  parameter int SEL_W      = 6,
  parameter int DEV_ADDR_W = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  main_clk,
  input  logic                  main_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [15:0]           req_wdata,
  input  logic                  req_write,
  input  logic                  req_byte,
  output logic                  resp_valid,
  output logic [15:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  err_sticky,
  input  logic                  err_clr,
  output logic [NUM_DEV-1:0]    dev_sel,
  output logic                  dev_we,
  output logic [DEV_ADDR_W-1:0] dev_addr,
  output logic [15:0]           dev_wdata,
  output logic [1:0]            dev_be,
  input  logic [NUM_DEV*16-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]    dev_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  state_t state_q, state_d;
  req_t req_q, req_d;
  logic [SEL_W-1:0] idx_q, idx_d, idx_in;
  logic [CW-1:0] cnt_q, cnt_d;
  logic req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic err_sticky_q, err_sticky_d, dev_we_q, dev_we_d;
  logic [15:0] resp_rdata_q, resp_rdata_d, dev_wdata_q, dev_wdata_d;
  logic [NUM_DEV-1:0] dev_sel_q, dev_sel_d, onehot;
  logic [DEV_ADDR_W-1:0] dev_addr_q, dev_addr_d;
  logic [1:0] dev_be_q, dev_be_d, fmt_be;
  logic [15:0] fmt_wdata, fmt_rdata, rword;
  logic idle, bad, rdy, unused_addr;
  assign idle        = state_q == IDLE;
  assign idx_in      = req_addr[SEL_LSB+SEL_W-1:SEL_LSB];
  assign bad         = !req_addr[31] || 32'(idx_in) >= 32'(NUM_DEV);
  assign unused_addr = ^req_q.addr[31:1];
  always_comb begin
    onehot = '0;
    rword  = '0;
    rdy    = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) begin
      onehot[i] = idx_in == SEL_W'(i);
      rword     = idx_q == SEL_W'(i) ? dev_rdata[16*i +: 16] : rword;
      rdy       = rdy | (idx_q == SEL_W'(i) && dev_ready[i]);
    end
  end
  // Formats the incoming request while idle, the latched one during the access
  mmio_lane_fmt u_fmt (
    .byte_op  (idle ? req_byte : req_q.byte_op),
    .a0       (idle ? req_addr[0] : req_q.addr[0]),
    .wdata    (idle ? req_wdata : req_q.wdata),
    .rword    (rword),
    .wdata_fmt(fmt_wdata),
    .be       (fmt_be),
    .rdata_fmt(fmt_rdata)
  );
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    dev_sel_d    = dev_sel_q;
    dev_we_d     = dev_we_q;
    dev_addr_d   = dev_addr_q;
    dev_wdata_d  = dev_wdata_q;
    dev_be_d     = dev_be_q;
    if (idle && req_valid) begin
      req_d = '{addr: req_addr, wdata: req_wdata, write: req_write, byte_op: req_byte};
      idx_d = idx_in;
      cnt_d = '0;
      if (bad) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end else begin
        state_d     = ACCESS;
        dev_sel_d   = onehot;
        dev_we_d    = req_write;
        dev_addr_d  = req_addr[DEV_ADDR_W-1:0];
        dev_wdata_d = fmt_wdata;
        dev_be_d    = fmt_be;
      end
    end else if (state_q == ACCESS) begin
      // A ready arriving on the final wait cycle still completes cleanly
      if (rdy || cnt_q == CNT_LAST) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = !rdy;
        resp_rdata_d = rdy && !req_q.write ? fmt_rdata : '0;
        dev_sel_d    = '0;
        dev_we_d     = 1'b0;
        dev_addr_d   = '0;
        dev_wdata_d  = '0;
        dev_be_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    req_ready_d  = state_d == IDLE;
    err_sticky_d = resp_err_d | (err_sticky_q & !err_clr);
  end
  always_ff @(posedge main_clk) begin
    if (!main_rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      err_sticky_q <= 1'b0;
      dev_sel_q    <= '0;
      dev_we_q     <= 1'b0;
      dev_addr_q   <= '0;
      dev_wdata_q  <= '0;
      dev_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      err_sticky_q <= err_sticky_d;
      dev_sel_q    <= dev_sel_d;
      dev_we_q     <= dev_we_d;
      dev_addr_q   <= dev_addr_d;
      dev_wdata_q  <= dev_wdata_d;
      dev_be_q     <= dev_be_d;
    end
  end
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign err_sticky = err_sticky_q;
  assign dev_sel    = dev_sel_q;
  assign dev_we     = dev_we_q;
  assign dev_addr   = dev_addr_q;
  assign dev_wdata  = dev_wdata_q;
  assign dev_be     = dev_be_q;
endmodule

// File: tb/tb_mmio_fabric.sv
// tb_mmio_fabric: scoreboard-driven self-checking bench for mmio_fabric
module tb_mmio_fabric;
  localparam int ND = 4;
  logic main_clk = 1'b0, main_rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0, err_clr = 1'b0;
  logic req_ready, resp_valid, resp_err, err_sticky, dev_we;
  logic [31:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] resp_rdata, dev_addr, dev_wdata;
  logic [ND-1:0] dev_sel, dev_ready = '0;
  logic [1:0] dev_be;
  logic [ND*16-1:0] dev_rdata;
  logic [15:0] ch_word [ND];
  int checks = 0, errors = 0;
  logic [16:0] exp_q [$];
  int wait_cfg = 0, acc_cycles = 0;
  bit other_rdy = 0, acc_unstable = 0;
  logic [ND-1:0] acc_sel;
  logic acc_we;
  logic [15:0] acc_addr, acc_wdata;
  logic [1:0] acc_be;

  always #5 main_clk = ~main_clk;

  mmio_fabric #(.NUM_DEV(ND), .TIMEOUT(4)) dut (
    .main_clk(main_clk), .main_rst_n(main_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_byte(req_byte),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .err_sticky(err_sticky), .err_clr(err_clr),
    .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_be(dev_be), .dev_rdata(dev_rdata), .dev_ready(dev_ready)
  );

  always_comb for (int i = 0; i < ND; i++) dev_rdata[16*i +: 16] = ch_word[i];

  // Device model and access monitor: ready after wait_cfg cycles of selection
  always @(negedge main_clk) begin
    if (dev_sel != '0) begin
      if (acc_cycles == 0) {acc_sel, acc_we, acc_addr, acc_wdata, acc_be} = {dev_sel, dev_we, dev_addr, dev_wdata, dev_be};
      else if ({dev_sel, dev_we, dev_addr, dev_wdata, dev_be} !== {acc_sel, acc_we, acc_addr, acc_wdata, acc_be}) acc_unstable = 1;
      dev_ready = ((acc_cycles >= wait_cfg) ? dev_sel : '0) | (other_rdy ? ~dev_sel : '0);
      acc_cycles++;
    end else dev_ready = other_rdy ? '1 : '0;
  end

  task automatic issue(input logic [31:0] a, input logic [15:0] wd, input logic wr, input logic by, input logic [16:0] e);
    for (int n = 0; n < 20 && req_ready !== 1'b1; n++) @(negedge main_clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL issue_ready got=%b exp=1", req_ready); end
    acc_cycles = 0; acc_unstable = 0;
    req_addr = a; req_wdata = wd; req_write = wr; req_byte = by; req_valid = 1;
    exp_q.push_back(e);
    @(posedge main_clk); #1 req_valid = 0;
  endtask

  task automatic wait_resp(output int lat, output logic [16:0] got, output logic st, output logic [16:0] e);
    lat = -1; got = 'x; st = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge main_clk);
      if (resp_valid) begin lat = n; got = {resp_rdata, resp_err}; st = err_sticky; break; end
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
  endtask

  task automatic test_reset();
    main_rst_n = 0; repeat (3) @(negedge main_clk);
    checks++; if ({req_ready, resp_valid, resp_rdata, resp_err, err_sticky, dev_sel, dev_we, dev_addr, dev_wdata, dev_be} !== {1'b1, 58'b0}) begin
      errors++; $display("FAIL reset_outputs rdy=%b vld=%b sel=%b sticky=%b", req_ready, resp_valid, dev_sel, err_sticky); end
    main_rst_n = 1; @(negedge main_clk);
  endtask

  task automatic test_word_read();
    int lat; logic [16:0] got, e; logic st;
    ch_word[1] = 16'hBEEF; wait_cfg = 0;
    issue(32'h8010_0004, 16'h0, 0, 0, {16'hBEEF, 1'b0});
    wait_resp(lat, got, st, e);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    checks++; if (got !== e) begin errors++; $display("FAIL wr_resp got=%h exp=%h", got, e); end
    checks++; if (acc_sel !== 4'b0010) begin errors++; $display("FAIL wr_sel got=%b exp=0010", acc_sel); end
    checks++; if (acc_we !== 1'b0) begin errors++; $display("FAIL wr_we got=%b exp=0", acc_we); end
    checks++; if (acc_addr !== 16'h0004) begin errors++; $display("FAIL wr_addr got=%h exp=0004", acc_addr); end
    checks++; if (acc_be !== 2'b11) begin errors++; $display("FAIL wr_be got=%b exp=11", acc_be); end
    checks++; if (acc_cycles != 1) begin errors++; $display("FAIL wr_cycles got=%0d exp=1", acc_cycles); end
  endtask

  task automatic test_byte_read();
    int lat; logic [16:0] got, e; logic st;
    ch_word[2] = 16'h12AB; wait_cfg = 1;
    issue(32'h8020_0003, 16'h0, 0, 1, {16'h0012, 1'b0});
    wait_resp(lat, got, st, e);
    checks++; if (got !== e) begin errors++; $display("FAIL br_hi_resp got=%h exp=%h", got, e); end
    checks++; if (acc_be !== 2'b10) begin errors++; $display("FAIL br_hi_be got=%b exp=10", acc_be); end
    issue(32'h8020_0002, 16'h0, 0, 1, {16'h00AB, 1'b0});
    wait_resp(lat, got, st, e);
    checks++; if (got !== e) begin errors++; $display("FAIL br_lo_resp got=%h exp=%h", got, e); end
    checks++; if (acc_be !== 2'b01) begin errors++; $display("FAIL br_lo_be got=%b exp=01", acc_be); end
  endtask

  task automatic test_byte_write();
    int lat; logic [16:0] got, e; logic st;
    ch_word[0] = 16'hFFFF; wait_cfg = 3;
    issue(32'h8000_0001, 16'h0077, 1, 1, {16'h0000, 1'b0});
    wait_resp(lat, got, st, e);
    checks++; if (lat != 5) begin errors++; $display("FAIL bw_latency got=%0d exp=5", lat); end
    checks++; if (got !== e) begin errors++; $display("FAIL bw_resp got=%h exp=%h", got, e); end
    checks++; if (acc_cycles != 4) begin errors++; $display("FAIL bw_cycles got=%0d exp=4", acc_cycles); end
    checks++; if (acc_unstable) begin errors++; $display("FAIL bw_stable got=changed exp=held"); end
    checks++; if (acc_wdata !== 16'h7777) begin errors++; $display("FAIL bw_wdata got=%h exp=7777", acc_wdata); end
    checks++; if (acc_be !== 2'b10) begin errors++; $display("FAIL bw_be got=%b exp=10", acc_be); end
    checks++; if (acc_we !== 1'b1) begin errors++; $display("FAIL bw_we got=%b exp=1", acc_we); end
    checks++; if (acc_sel !== 4'b0001) begin errors++; $display("FAIL bw_sel got=%b exp=0001", acc_sel); end
  endtask

  task automatic test_errors();
    int lat; logic [16:0] got, e; logic st;
    wait_cfg = 0;
    issue(32'h0000_1000, 16'h5555, 1, 0, {16'h0000, 1'b1});
    wait_resp(lat, got, st, e);
    checks++; if (lat != 1) begin errors++; $display("FAIL e1_latency got=%0d exp=1", lat); end
    checks++; if (got !== e) begin errors++; $display("FAIL e1_resp got=%h exp=%h", got, e); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL e1_sticky got=%b exp=1", st); end
    checks++; if (acc_cycles != 0) begin errors++; $display("FAIL e1_nosel got=%0d exp=0", acc_cycles); end
    issue(32'h8070_0000, 16'h0, 0, 0, {16'h0000, 1'b1});
    wait_resp(lat, got, st, e);
    checks++; if (got !== e) begin errors++; $display("FAIL e2_resp got=%h exp=%h", got, e); end
    checks++; if (acc_cycles != 0) begin errors++; $display("FAIL e2_nosel got=%0d exp=0", acc_cycles); end
    err_clr = 1; @(negedge main_clk); err_clr = 0;
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got=%b exp=0", err_sticky); end
    err_clr = 1;
    issue(32'h8040_0000, 16'h0, 0, 0, {16'h0000, 1'b1});
    wait_resp(lat, got, st, e);
    err_clr = 0;
    checks++; if (got !== e) begin errors++; $display("FAIL e3_resp got=%h exp=%h", got, e); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", st); end
  endtask

  task automatic test_timeout();
    int lat; logic [16:0] got, e; logic st;
    ch_word[3] = 16'h5A5A; wait_cfg = 1000; other_rdy = 1;
    issue(32'h8030_0000, 16'h0, 0, 0, {16'h0000, 1'b1});
    wait_resp(lat, got, st, e);
    checks++; if (lat != 5) begin errors++; $display("FAIL to_latency got=%0d exp=5", lat); end
    checks++; if (got !== e) begin errors++; $display("FAIL to_resp got=%h exp=%h", got, e); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", st); end
    checks++; if (acc_cycles != 4) begin errors++; $display("FAIL to_cycles got=%0d exp=4", acc_cycles); end
    wait_cfg = 3; other_rdy = 0;
    issue(32'h8030_0000, 16'h0, 0, 0, {16'h5A5A, 1'b0});
    wait_resp(lat, got, st, e);
    checks++; if (lat != 5) begin errors++; $display("FAIL edge_latency got=%0d exp=5", lat); end
    checks++; if (got !== e) begin errors++; $display("FAIL edge_resp got=%h exp=%h", got, e); end
  endtask

  task automatic test_back_to_back();
    int n_resp = 0, bad = 0;
    ch_word[0] = 16'h0101; wait_cfg = 0;
    for (int n = 0; n < 20 && req_ready !== 1'b1; n++) @(negedge main_clk);
    req_addr = 32'h8000_0000; req_write = 0; req_byte = 0; req_valid = 1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge main_clk);
      if (resp_valid) begin
        n_resp++;
        if ({resp_rdata, resp_err} !== {16'h0101, 1'b0} || req_ready) bad++;
      end
    end
    req_valid = 0;
    checks++; if (n_resp != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", n_resp); end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_data got=%0d bad exp=0", bad); end
  endtask

  task automatic test_reset_mid();
    int n_resp = 0;
    ch_word[1] = 16'h1234; wait_cfg = 1000;
    issue(32'h8010_0000, 16'h0, 0, 0, {16'h0000, 1'b0});
    repeat (2) @(negedge main_clk);
    checks++; if (dev_sel !== 4'b0010) begin errors++; $display("FAIL mid_sel got=%b exp=0010", dev_sel); end
    main_rst_n = 0; @(negedge main_clk);
    checks++; if ({req_ready, resp_valid, resp_rdata, resp_err, err_sticky, dev_sel, dev_we, dev_addr, dev_wdata, dev_be} !== {1'b1, 58'b0}) begin
      errors++; $display("FAIL mid_outputs rdy=%b vld=%b sel=%b sticky=%b", req_ready, resp_valid, dev_sel, err_sticky); end
    main_rst_n = 1;
    for (int n = 0; n < 10; n++) begin @(negedge main_clk); if (resp_valid) n_resp++; end
    checks++; if (n_resp != 0) begin errors++; $display("FAIL mid_noresp got=%0d exp=0", n_resp); end
    void'(exp_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < ND; i++) ch_word[i] = '0;
    test_reset();
    test_word_read();
    test_byte_read();
    test_byte_write();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
